// File: rtl/spell_host_pkg.sv
// Shared types and constants for the spell host bridge.
package spell_host_pkg;

  // Bridge FSM: IDLE arbitrates, BUS holds the target request, RESP acks/latches.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Origin of the transaction in flight, decides what RESP does with the data.
  typedef enum logic [1:0] {
    SRC_WB_RD = 2'd0,
    SRC_WB_WR = 2'd1,
    SRC_LA_WR = 2'd2,
    SRC_LA_RD = 2'd3
  } src_e;

  // Read data returned to Wishbone when a target never answers.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Target index width; at least one bit even for a single target.
  function automatic int tgt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spell_host_decode.sv
// Wishbone address decode: window hit, one-hot target select, word address.
module spell_host_decode
  import spell_host_pkg::*;
#(
  parameter int          ADDR_W  = 7,
  parameter int          N_TGT   = 1,
  parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
  input  logic [31:0]       adr_i,
  output logic              hit_o,
  output logic [N_TGT-1:0]  sel_o,
  output logic [ADDR_W-1:0] word_o
);

  localparam int          TGT_W  = tgt_w(N_TGT);
  localparam logic [32:0] WIN_LO = {1'b0, WB_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(N_TGT) << (ADDR_W + 2));

  logic [TGT_W-1:0] tgt;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  assign hit_o  = ({1'b0, adr_i} >= WIN_LO) && ({1'b0, adr_i} < WIN_HI);
  assign word_o = adr_i[ADDR_W+1:2];
  // Masking by N_TGT-1 makes the single-target case decode to target 0.
  assign tgt    = adr_i[ADDR_W+TGT_W+1:ADDR_W+2] & TGT_W'(N_TGT - 1);
  assign sel_o  = N_TGT'(1) << tgt;

endmodule

// File: rtl/spell_host_bridge.sv
// Host bridge: Wishbone slave + Logic Analyzer port onto a simple
// req/ready target bus. Optional bus timeout: SPELL_HOST_BRIDGE_TIMEOUT_EN.
module spell_host_bridge
  import spell_host_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 7,
  parameter int          N_TGT   = 1,
  parameter logic [31:0] WB_BASE = 32'h3000_0000,
  parameter int          TIMEOUT = 255,
  localparam int         TGT_W   = tgt_w(N_TGT)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic                    i_la_mode,
  input  logic                    i_la_write,
  input  logic [TGT_W+ADDR_W-1:0] i_la_addr,
  input  logic [DATA_W-1:0]       i_la_data,
  output logic [DATA_W-1:0]       o_la_rdata,
  output logic                    o_la_busy,
  output logic                    o_tgt_req,
  output logic                    o_tgt_we,
  output logic [N_TGT-1:0]        o_tgt_sel,
  output logic [ADDR_W-1:0]       o_tgt_addr,
  output logic [DATA_W-1:0]       o_tgt_wdata,
  input  logic                    i_tgt_ready,
  input  logic [DATA_W-1:0]       i_tgt_rdata,
  output logic                    o_timeout
);

  state_e              state_q;
  src_e                src_q;
  logic                la_write_q, la_pend_q;
  logic                req_q, we_q;
  logic [N_TGT-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rbuf_q, la_rdata_q;
  logic                ack_q, busy_q;
  logic [31:0]         dat_q;

  logic                wb_hit, wb_req, la_edge, txn_to;
  logic [N_TGT-1:0]    wb_sel, la_sel;
  logic [ADDR_W-1:0]   wb_word;
  logic [TGT_W-1:0]    la_tgt;
  logic [DATA_W-1:0]   wb_wdata;

  spell_host_decode #(
    .ADDR_W  (ADDR_W),
    .N_TGT   (N_TGT),
    .WB_BASE (WB_BASE)
  ) u_decode (
    .adr_i  (wbs_adr_i),
    .hit_o  (wb_hit),
    .sel_o  (wb_sel),
    .word_o (wb_word)
  );

  // The ack cycle still shows cyc&stb; masking with ack_q stops a double accept.
  assign wb_req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign la_edge  = i_la_write & ~la_write_q;
  assign la_tgt   = i_la_addr[TGT_W+ADDR_W-1:ADDR_W] & TGT_W'(N_TGT - 1);
  assign la_sel   = N_TGT'(1) << la_tgt;
  assign wb_wdata = wbs_dat_i[DATA_W-1:0];

  // Upper WB write bits are dropped when the target is narrower than 32 bits.
  if (DATA_W < 32) begin : g_trunc
    logic unused_dat_hi;
    assign unused_dat_hi = ^wbs_dat_i[31:DATA_W];
  end

`ifdef SPELL_HOST_BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit_q, timeout_q, la_mode_q;

  // Timeout bookkeeping: per-transaction cycle counter and sticky flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt_q  <= '0;
      to_hit_q  <= 1'b0;
      timeout_q <= 1'b0;
      la_mode_q <= 1'b0;
    end else begin
      la_mode_q <= i_la_mode;
      if (i_la_mode && !la_mode_q) timeout_q <= 1'b0;
      case (state_q)
        ST_BUS: begin
          if (!i_tgt_ready) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
              to_hit_q  <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        ST_RESP: to_hit_q <= 1'b0;
        default: to_cnt_q <= '0;
      endcase
    end
  end

  // Ready wins over expiry when both land in the same cycle.
  logic to_fire;
  assign to_fire   = (to_cnt_q == TO_W'(TIMEOUT - 1)) && !i_tgt_ready;
  assign txn_to    = to_hit_q;
  assign o_timeout = timeout_q;
`else
  logic to_fire;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_fire   = 1'b0;
  assign txn_to    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Main FSM: arbitration in IDLE, request hold in BUS, ack/latch in RESP.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_WB_RD;
      la_write_q <= 1'b0;
      la_pend_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      la_rdata_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      dat_q      <= '0;
    end else begin
      la_write_q <= i_la_write;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      case (state_q)
        ST_IDLE: begin
          if (i_la_mode) begin
            if (la_edge || la_pend_q) begin
              state_q   <= ST_BUS;
              src_q     <= SRC_LA_WR;
              req_q     <= 1'b1;
              we_q      <= 1'b1;
              sel_q     <= la_sel;
              addr_q    <= i_la_addr[ADDR_W-1:0];
              wdata_q   <= i_la_data;
              busy_q    <= 1'b1;
              la_pend_q <= 1'b0;
            end else if (wb_req) begin
              // LA owns the bus: null-ack any WB access, writes are dropped.
              ack_q <= 1'b1;
            end else begin
              state_q <= ST_BUS;
              src_q   <= SRC_LA_RD;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              sel_q   <= la_sel;
              addr_q  <= i_la_addr[ADDR_W-1:0];
              busy_q  <= 1'b1;
            end
          end else begin
            // A pending LA write is stale once the host has left LA mode.
            la_pend_q <= 1'b0;
            if (wb_req) begin
              if (wb_hit) begin
                state_q <= ST_BUS;
                src_q   <= wbs_we_i ? SRC_WB_WR : SRC_WB_RD;
                req_q   <= 1'b1;
                we_q    <= wbs_we_i;
                sel_q   <= wb_sel;
                addr_q  <= wb_word;
                wdata_q <= wb_wdata;
              end else begin
                ack_q <= 1'b1;
              end
            end
          end
        end
        ST_BUS: begin
          if (la_edge) la_pend_q <= 1'b1;
          if (i_tgt_ready || to_fire) begin
            state_q <= ST_RESP;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rbuf_q  <= i_tgt_rdata;
          end
        end
        ST_RESP: begin
          if (la_edge) la_pend_q <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          case (src_q)
            SRC_WB_RD, SRC_WB_WR: begin
              // A master that dropped cyc has abandoned the cycle: no ack.
              if (wbs_cyc_i && wbs_stb_i) begin
                ack_q <= 1'b1;
                if (txn_to)                dat_q <= TIMEOUT_RDATA;
                else if (src_q == SRC_WB_RD) dat_q <= 32'(rbuf_q);
              end
            end
            SRC_LA_RD: if (!txn_to) la_rdata_q <= rbuf_q;
            default: ;
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign o_la_rdata  = la_rdata_q;
  assign o_la_busy   = busy_q;
  assign o_tgt_req   = req_q;
  assign o_tgt_we    = we_q;
  assign o_tgt_sel   = sel_q;
  assign o_tgt_addr  = addr_q;
  assign o_tgt_wdata = wdata_q;

endmodule

// File: tb/tb_spell_host_bridge.sv
// Scoreboard bench for spell_host_bridge (4 targets, 8-bit data, 7-bit words).
module tb_spell_host_bridge;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int N_TGT  = 4;
  localparam int TGT_W  = 2;
`ifdef SPELL_HOST_BRIDGE_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cyc = 0, stb = 0, we = 0;
  logic [31:0]             adr = '0, wdat = '0;
  logic                    ack;
  logic [31:0]             rdat;
  logic                    la_mode = 0, la_write = 0;
  logic [TGT_W+ADDR_W-1:0] la_addr = '0;
  logic [DATA_W-1:0]       la_data = '0;
  logic [DATA_W-1:0]       la_rdata;
  logic                    la_busy;
  logic                    tgt_req, tgt_we, tgt_ready;
  logic [N_TGT-1:0]        tgt_sel;
  logic [ADDR_W-1:0]       tgt_addr;
  logic [DATA_W-1:0]       tgt_wdata, tgt_rdata;
  logic                    timeout;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_rsp[$];
  logic [31:0] exp_wr[$];
  logic [N_TGT-1:0] last_rd_sel = '0;
  int  lat;

  // Target model state
  bit [7:0] mem [512];
  int waits = 0;
  bit ready_en = 1;
  int wcnt = 0;

  always #5 clk = ~clk;

  spell_host_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_TGT(N_TGT),
    .WB_BASE(32'h3000_0000), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .i_la_mode(la_mode), .i_la_write(la_write),
    .i_la_addr(la_addr), .i_la_data(la_data),
    .o_la_rdata(la_rdata), .o_la_busy(la_busy),
    .o_tgt_req(tgt_req), .o_tgt_we(tgt_we), .o_tgt_sel(tgt_sel),
    .o_tgt_addr(tgt_addr), .o_tgt_wdata(tgt_wdata),
    .i_tgt_ready(tgt_ready), .i_tgt_rdata(tgt_rdata),
    .o_timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mem_idx(input logic [N_TGT-1:0] s, input logic [ADDR_W-1:0] a);
    int t = 0;
    for (int i = 0; i < N_TGT; i++) if (s[i]) t = i;
    return t * 128 + int'(a);
  endfunction

  assign tgt_ready = tgt_req && ready_en && (wcnt >= waits);
  always_comb tgt_rdata = mem[mem_idx(tgt_sel, tgt_addr)];

  // Target: wait-state counter and write storage
  always @(posedge clk) begin
    if (tgt_req && !tgt_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (tgt_req && tgt_ready && tgt_we) mem[mem_idx(tgt_sel, tgt_addr)] <= tgt_wdata;
  end

  // Scoreboard: target writes and WB responses checked against queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (tgt_req && tgt_ready) begin
        if (tgt_we) begin
          chk("tgt_wr_expected", 32'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0)
            chk("tgt_wr", {13'd0, tgt_sel, tgt_addr, tgt_wdata}, exp_wr.pop_front());
        end else begin
          last_rd_sel = tgt_sel;
        end
      end
      if (ack) begin
        chk("ack_expected", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) chk("wb_dat", rdat, exp_rsp.pop_front());
      end
    end
  end

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] e, output int l);
    bit got = 0;
    exp_rsp.push_back(e);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    for (l = 0; l < 200; l++) begin
      @(negedge clk);
      if (ack) begin got = 1; break; end
      @(posedge clk);
    end
    if (!got) chk("ack_seen", 32'(ack), 1);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  function automatic logic [31:0] wr_ent(input logic [N_TGT-1:0] s, input int a, input logic [7:0] d);
    return {13'd0, s, ADDR_W'(a), d};
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", rdat, 0);
    chk("rst_req", {tgt_req, tgt_we, tgt_sel}, 0);
    chk("rst_tgt", {tgt_addr, tgt_wdata}, 0);
    chk("rst_la", {la_busy, la_rdata, timeout}, 0);
    @(posedge clk); #1 rst_n = 1;

    // WB write, ready in first BUS cycle: ack 3 cycles after request
    waits = 0;
    exp_wr.push_back(wr_ent(4'b0001, 2, 8'h5A));
    wb_xfer(1, 32'h3000_0008, 32'h0000_005A, 32'h0, lat);
    chk("wr_latency", lat, 3);
    waits = 2;
    wb_xfer(0, 32'h3000_0008, 0, 32'h5A, lat);
    chk("rd_latency_w2", lat, 5);

    // Target 1 word 1, read with 4 wait states
    waits = 0;
    exp_wr.push_back(wr_ent(4'b0010, 1, 8'hC3));
    wb_xfer(1, 32'h3000_0204, 32'h0000_00C3, 32'h0, lat);
    waits = 4;
    wb_xfer(0, 32'h3000_0204, 0, 32'hC3, lat);
    chk("rd_sel", last_rd_sel, 4'b0010);
    chk("rd_latency_w4", lat, 7);

    // Wide WB data truncated on write, zero-extended on read; adr[1:0] ignored
    waits = 0;
    exp_wr.push_back(wr_ent(4'b0001, 3, 8'hA5));
    wb_xfer(1, 32'h3000_000C, 32'h1234_56A5, 32'h0, lat);
    wb_xfer(0, 32'h3000_000F, 0, 32'hA5, lat);

    // Last word of the window
    exp_wr.push_back(wr_ent(4'b1000, 127, 8'h7E));
    wb_xfer(1, 32'h3000_07FC, 32'h7E, 32'h0, lat);
    wb_xfer(0, 32'h3000_07FC, 0, 32'h7E, lat);

    // Window misses on both sides: ack next cycle, no target access
    wb_xfer(0, 32'h3000_0800, 0, 32'h0, lat);
    chk("miss_hi_latency", lat, 1);
    wb_xfer(1, 32'h2FFF_FFFC, 32'h99, 32'h0, lat);
    chk("miss_lo_latency", lat, 1);

    // Reset while a WB write is stuck in BUS
    ready_en = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0000; wdat = 32'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bus_req_held", {tgt_req, tgt_we, tgt_sel}, {1'b1, 1'b1, 4'b0001});
    chk("wb_no_busy", 32'(la_busy), 0);
    #1 rst_n = 0;
    #1;
    chk("midrst_req", {tgt_req, tgt_we, tgt_sel}, 0);
    chk("midrst_ack", {ack, rdat}, 0);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1 rst_n = 1; ready_en = 1;

    // LA mode: polls run, one write per rising edge of la_write
    la_addr = 9'h010; la_data = 8'h81; la_mode = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (tgt_req) begin seen = 1; break; end
      end
      chk("la_poll_req", 32'(seen), 1);
      chk("la_busy", 32'(la_busy), 1);
    end
    exp_wr.push_back(wr_ent(4'b0001, 7'h10, 8'h81));
    @(posedge clk); #1 la_write = 1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("la_wr_done", exp_wr.size(), 0);
    chk("la_rdata", la_rdata, 8'h81);

    // LA owns bus: WB read and write are null-acked, write dropped
    wb_xfer(0, 32'h3000_0008, 0, 32'h0, lat);
    chk("null_rd_bounded", 32'(lat <= 6), 1);
    wb_xfer(1, 32'h3000_0008, 32'h77, 32'h0, lat);
    la_addr = 9'h002;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("la_poll_resume", la_rdata, 8'h5A);

    // Back to WB mode
    la_write = 0; la_mode = 0;
    wb_xfer(0, 32'h3000_0008, 0, 32'h5A, lat);

`ifdef SPELL_HOST_BRIDGE_TIMEOUT_EN
    // Target never answers: timeout ack, sticky flag until LA mode rises
    ready_en = 0;
    wb_xfer(0, 32'h3000_0004, 0, 32'hDEAD_BEEF, lat);
    chk("to_latency", lat, TIMEOUT + 2);
    @(negedge clk);
    chk("to_flag_set", 32'(timeout), 1);
    chk("to_req_drop", 32'(tgt_req), 0);
    ready_en = 1;
    @(posedge clk); #1 la_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("to_flag_clr", 32'(timeout), 0);
    la_mode = 0;
    repeat (5) @(posedge clk);
`else
    @(negedge clk);
    chk("to_flag_off", 32'(timeout), 0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", exp_rsp.size() + exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
